// File: rtl/mul_cell_combine_pkg.sv
// Shared multiplier-combine definitions: tag width, S1 stage record,
// result-word select and the 34-bit extension helper used by the mid adder.
package mul_cell_combine_pkg;

    localparam int MUL_TAG_W = 5;
    localparam int MUL_MID_W = 34;

    // Which 32-bit half of the 64-bit product is returned.
    typedef enum logic {
        MUL_LO = 1'b0,
        MUL_HI = 1'b1
    } mul_sel_e;

    // Contents of the first pipeline stage.
    typedef struct packed {
        logic                  valid;
        mul_sel_e              hi;
        logic [MUL_TAG_W-1:0]  dst;
        logic [31:0]           p1;
        logic [31:0]           p4;
        logic [MUL_MID_W-1:0]  mid;
    } mul_s1_t;

    // Widen a 32-bit partial product to 34 bits, sign- or zero-extending.
    function automatic logic [MUL_MID_W-1:0] ext34(input logic [31:0] v, input logic s);
        return s ? {{2{v[31]}}, v} : {2'b00, v};
    endfunction

endpackage

// File: rtl/mul_cell_combine_add64.sv
// Second pipeline stage: shift-adds the S1 record into the product and
// registers the selected word, tag and valid bit.
// MUL_CELL_COMBINE_HI_EN defined  : full 64-bit add, i_sel picks the word.
// MUL_CELL_COMBINE_HI_EN undefined: 32-bit add only; high-word requests
//                                   arrive already zeroed from S1.
module mul_cell_combine_add64
    import mul_cell_combine_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  mul_sel_e             i_sel,
    input  logic [TAG_W-1:0]     i_dst,
    input  logic [31:0]          i_p1,
    input  logic [31:0]          i_p4,
    input  logic [MUL_MID_W-1:0] i_mid,
    output logic                 o_valid,
    output logic [31:0]          o_result,
    output logic [TAG_W-1:0]     o_dst
);

    logic             valid_d, valid_q;
    logic [31:0]      result_d, result_q;
    logic [TAG_W-1:0] dst_d, dst_q;
    logic [31:0]      word;

`ifdef MUL_CELL_COMBINE_HI_EN
    logic [63:0] prod;

    // {p4,p1} plus the sign-extended middle term at bit 16; p4 needs no
    // extension since its upper bits land above bit 63.
    assign prod = {i_p4, i_p1} + ({{(64 - MUL_MID_W){i_mid[MUL_MID_W-1]}}, i_mid} << 16);
    assign word = (i_sel == MUL_HI) ? prod[63:32] : prod[31:0];
`else
    logic unused_hi_path;

    // Only the low word exists; mid bits above 15 fall outside it.
    assign word           = i_p1 + {i_mid[15:0], 16'h0000};
    assign unused_hi_path = ^{i_sel, i_p4, i_mid[MUL_MID_W-1:16]};
`endif

    // Next-state: flush kills the valid bit even while stalled.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        dst_d    = dst_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_en) begin
            valid_d  = i_valid;
            result_d = word;
            dst_d    = i_dst;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            dst_q    <= dst_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_dst    = dst_q;

endmodule

// File: rtl/mul_cell_combine.sv
// Combines the four 16x16 partial products of the multiplier cell into the
// selected 32-bit word of the 64-bit product over two enabled stages.
// Optional feature macro: MUL_CELL_COMBINE_HI_EN (high-word support).
// The S1 tag field is MUL_TAG_W wide; TAG_W is expected to equal it.
module mul_cell_combine
    import mul_cell_combine_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_hi,
    input  logic             i_src1_signed,
    input  logic             i_src2_signed,
    input  logic [31:0]      i_p1,
    input  logic [31:0]      i_p2,
    input  logic [31:0]      i_p3,
    input  logic [31:0]      i_p4,
    input  logic [TAG_W-1:0] i_dst,
    output logic             o_valid,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_dst,
    output logic             o_busy
);

    mul_s1_t s1_d, s1_q;

`ifndef MUL_CELL_COMBINE_HI_EN
    logic unused_p4;
    assign unused_p4 = ^i_p4;
`endif

    // S1 next-state: middle-term add kept here so S2 only does the wide add.
    always_comb begin
        s1_d = s1_q;
        if (i_flush) begin
            s1_d.valid = 1'b0;
        end else if (i_en) begin
            s1_d.valid = i_valid;
            s1_d.dst   = MUL_TAG_W'(i_dst);
            s1_d.p1    = i_p1;
            s1_d.mid   = ext34(i_p2, i_src2_signed) + ext34(i_p3, i_src1_signed);
`ifdef MUL_CELL_COMBINE_HI_EN
            s1_d.hi    = i_hi ? MUL_HI : MUL_LO;
            s1_d.p4    = i_p4;
`else
            // High word unsupported: zero the operands so S2 yields 0.
            s1_d.hi    = MUL_LO;
            s1_d.p4    = '0;
            if (i_hi) begin
                s1_d.p1  = '0;
                s1_d.mid = '0;
            end
`endif
        end
    end

    // S1 register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    mul_cell_combine_add64 #(
        .TAG_W (TAG_W)
    ) u_add64 (
        .clk      (clk),
        .reset    (reset),
        .i_en     (i_en),
        .i_flush  (i_flush),
        .i_valid  (s1_q.valid),
        .i_sel    (s1_q.hi),
        .i_dst    (TAG_W'(s1_q.dst)),
        .i_p1     (s1_q.p1),
        .i_p4     (s1_q.p4),
        .i_mid    (s1_q.mid),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_dst    (o_dst)
    );

    assign o_busy = s1_q.valid | o_valid;

endmodule

// File: tb/tb_mul_cell_combine.sv
// Self-checking bench for mul_cell_combine: directed cases plus randomized
// traffic scored against a multiply-level reference model.
module tb_mul_cell_combine;

    localparam int TAG_W = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             i_en, i_flush, i_valid, i_hi, i_src1_signed, i_src2_signed;
    logic [31:0]      i_p1, i_p2, i_p3, i_p4;
    logic [TAG_W-1:0] i_dst;
    logic             o_valid, o_busy;
    logic [31:0]      o_result;
    logic [TAG_W-1:0] o_dst;

    mul_cell_combine #(.TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_en          (i_en),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .i_hi          (i_hi),
        .i_src1_signed (i_src1_signed),
        .i_src2_signed (i_src2_signed),
        .i_p1          (i_p1),
        .i_p2          (i_p2),
        .i_p3          (i_p3),
        .i_p4          (i_p4),
        .i_dst         (i_dst),
        .o_valid       (o_valid),
        .o_result      (o_result),
        .o_dst         (o_dst),
        .o_busy        (o_busy)
    );

    // ---------------- scoreboard state ----------------
    logic [TAG_W+31:0] exp_q[$];   // {dst, result} of accepted operations
    int                at_q[$];    // enabled-edge index at which each was accepted
    int                en_cnt = 0;
    int                seen   = 0;
    logic [31:0]       cur_exp;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: return the requested word of a full product.
    function automatic logic [31:0] sel_word(input logic [63:0] prod, input logic hi);
`ifdef MUL_CELL_COMBINE_HI_EN
        return hi ? prod[63:32] : prod[31:0];
`else
        return hi ? 32'h0 : prod[31:0];
`endif
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pp(input logic [31:0] p1, p2, p3, p4, input logic s1, s2, hi,
                           input logic [TAG_W-1:0] dst, input logic [31:0] exp);
        i_p1 = p1; i_p2 = p2; i_p3 = p3; i_p4 = p4;
        i_src1_signed = s1; i_src2_signed = s2; i_hi = hi; i_dst = dst;
        i_valid = 1'b1;
        cur_exp = exp;
    endtask

    // Build partial products for a*b as the cell would and expect the
    // corresponding word of the true 64-bit product.
    task automatic load_op(input logic [31:0] a, b, input logic s1, s2, hi,
                           input logic [TAG_W-1:0] dst);
        logic [63:0] ea, eb, prod;
        logic [31:0] al, ah, bl, bh;
        ea = s1 ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s2 ? {{32{b[31]}}, b} : {32'h0, b};
        prod = ea * eb;
        al = {16'h0, a[15:0]};
        bl = {16'h0, b[15:0]};
        ah = s1 ? {{16{a[31]}}, a[31:16]} : {16'h0, a[31:16]};
        bh = s2 ? {{16{b[31]}}, b[31:16]} : {16'h0, b[31:16]};
        load_pp(al * bl, al * bh, ah * bl, ah * bh, s1, s2, hi, dst, sel_word(prod, hi));
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        bit exp_v;
        if (reset) begin
            check("rst_valid", o_valid, 0);
            check("rst_busy", o_busy, 0);
            exp_q.delete();
            at_q.delete();
        end else begin
            exp_v = 1'b0;
            if (exp_q.size() != 0) exp_v = (en_cnt - at_q[0]) >= 1;
            check("valid", o_valid, exp_v);
            check("busy", o_busy, exp_q.size() != 0);
            if (o_valid && exp_v) begin
                check("result", o_result, exp_q[0][31:0]);
                check("dst", o_dst, exp_q[0][TAG_W+31:32]);
            end
            if (o_valid && i_en && !i_flush) seen++;
            if (i_en && !i_flush && exp_v) begin
                void'(exp_q.pop_front());
                void'(at_q.pop_front());
            end
            if (i_flush) begin
                exp_q.delete();
                at_q.delete();
            end
            if (i_en && !i_flush && i_valid) begin
                exp_q.push_back({i_dst, cur_exp});
                at_q.push_back(en_cnt + 1);
            end
            if (i_en) en_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen0;
        i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_hi = 1'b0;
        i_src1_signed = 1'b0; i_src2_signed = 1'b0;
        i_p1 = '0; i_p2 = '0; i_p3 = '0; i_p4 = '0; i_dst = '0; cur_exp = '0;
        #1 reset = 1'b1;
        step();
        check("rst_result", o_result, 0);
        check("rst_dst", o_dst, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_valid", o_valid, 0);

        // Unsigned low/high words, with explicit 2-cycle latency check.
        load_pp(32'h8, 32'hA, 32'hC, 32'hF, 0, 0, 0, 5'd1, sel_word(64'h0000000F_00160008, 0));
        step();
        i_valid = 1'b0;
        check("lat_s1", o_valid, 0);
        step();
        check("lat_s2", o_valid, 1);
        check("u_lo", o_result, 32'h00160008);
        load_pp(32'h8, 32'hA, 32'hC, 32'hF, 0, 0, 1, 5'd2, sel_word(64'h0000000F_00160008, 1));
        step();
        idle(1);
`ifdef MUL_CELL_COMBINE_HI_EN
        check("u_hi", o_result, 32'h0000000F);
`else
        check("u_hi_off", o_result, 32'h00000000);
`endif
        idle(2);

        // Signed x signed: -1 * 2.
        load_pp(32'h0001FFFE, 32'h0, 32'hFFFFFFFE, 32'h0, 1, 1, 0, 5'd3,
                sel_word(64'hFFFFFFFF_FFFFFFFE, 0));
        step();
        load_pp(32'h0001FFFE, 32'h0, 32'hFFFFFFFE, 32'h0, 1, 1, 1, 5'd4,
                sel_word(64'hFFFFFFFF_FFFFFFFE, 1));
        step();
        // mulxuu of all-ones operands.
        load_pp(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 1, 5'd5,
                sel_word(64'hFFFFFFFE_00000001, 1));
        step();
        idle(3);

        // Back-to-back stream with a two-cycle stall in the middle.
        seen0 = seen;
        load_op($urandom, $urandom, 1, 0, 0, 5'd1); step();
        load_op($urandom, $urandom, 0, 1, 1, 5'd2); step();
        i_valid = 1'b0; i_en = 1'b0;
        step(); step();
        i_en = 1'b1;
        load_op($urandom, $urandom, 1, 1, 0, 5'd3); step();
        idle(3);
        check("stream_count", seen - seen0, 3);

        // Flush with S1, S2 and a new request all live.
        seen0 = seen;
        load_op($urandom, $urandom, 0, 0, 0, 5'd7); step();
        load_op($urandom, $urandom, 0, 0, 1, 5'd8); step();
        load_op($urandom, $urandom, 1, 1, 0, 5'd9);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush_valid", o_valid, 0);
        check("flush_busy", o_busy, 0);
        idle(3);
        check("flush_count", seen - seen0, 0);

        // Asynchronous reset with S2 valid, asserted between edges.
        load_op($urandom, $urandom, 0, 0, 0, 5'd11); step();
        load_op($urandom, $urandom, 0, 0, 0, 5'd12); step();
        i_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_result", o_result, 0);
        check("arst_dst", o_dst, 0);
        check("arst_busy", o_busy, 0);
        step();
        reset = 1'b0;
        idle(3);

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            load_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 31)));
            i_valid = ($urandom_range(0, 9) < 7);
            i_en    = ($urandom_range(0, 9) != 0);
            i_flush = ($urandom_range(0, 29) == 0);
            step();
        end
        i_en = 1'b1; i_flush = 1'b0;
        idle(4);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
